control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Upstream control stage of the 8-bit CPU datapath.
- Steps through fetch/execute T-states and decodes the instruction register's opcode.
- Drives the load-enable (En) and bus-output strobes of the Reg8Bit-style registers (MAR, IR, A, B, OUT) plus the PC and RAM.
- All register loads take effect on the CLK edge that ends the T-state in which the enable is high.

Parameters:
- SKIP_IDLE, 0: when 1, an instruction returns to T1 right after its last active T-state; when 0, every instruction takes exactly 6 T-states.
- OPW, 4: opcode width, taken from the top bits of IR_Q (IR_Q[7:8-OPW]).

Ports:
- CLK in 1: system clock, rising edge.
- CLR in 1: synchronous, active-high reset.
- Run in 1: step enable; 0 freezes the sequencer.
- IR_Q in 8: current instruction register contents; opcode is [7:4], operand is [3:0].
- PC_Inc out 1: program counter increments this edge.
- PC_Out out 1: PC drives the bus.
- MAR_Ld out 1: En to the MAR register.
- RAM_Out out 1: RAM drives the bus.
- IR_Ld out 1: En to IR.
- IR_Out out 1: IR operand nibble drives the bus.
- A_Ld out 1: En to the A register.
- A_Out out 1: A drives the bus.
- B_Ld out 1: En to the B register.
- ALU_Out out 1: ALU result drives the bus.
- ALU_Sub out 1: ALU subtract select.
- OUT_Ld out 1: En to the output register.
- Halted out 1: registered halt flag.
- TState out 3: current T-state, 1..6; 0 while halted.

Behaviour:
- State: a one-hot ring T1..T6 plus a HALT state, all registered.
- On any CLK edge with CLR=1:
  - state goes to T1 and Halted goes to 0.
  - All strobe outputs are forced to 0 combinationally during that cycle.
- Strobe outputs are a combinational decode of the state register and IR_Q, valid for the whole T-state.
- Any cycle with Run=0:
  - All strobes are 0.
  - State holds.
  - TState still reports the held state.
- Fetch (all opcodes):
  - T1: PC_Out, MAR_Ld.
  - T2: PC_Inc.
  - T3: RAM_Out, IR_Ld.
- Decode: opcode is sampled from IR_Q at T4–T6 only. IR is loaded at the end of T3, so IR_Q is valid from T4.
- Opcode 0x0, LDA:
  - T4: IR_Out, MAR_Ld.
  - T5: RAM_Out, A_Ld.
  - T6: no strobes.
- Opcode 0x1, ADD:
  - T4: IR_Out, MAR_Ld.
  - T5: RAM_Out, B_Ld.
  - T6: ALU_Out, A_Ld.
- Opcode 0x2, SUB: same as ADD, with ALU_Sub=1 in T6 only.
- Opcode 0xE, OUT:
  - T4: A_Out, OUT_Ld.
  - T5, T6: no strobes.
- Opcode 0xF, HLT:
  - T4: no strobes; the next state is HALT and Halted is set on that edge.
  - HALT is left only by CLR; Run has no effect while halted.
- All other opcodes are NOPs: T4–T6 assert no strobes.
- Transitions:
  - Tn→Tn+1 when Run=1.
  - T6→T1 when Run=1.
- With SKIP_IDLE=1:
  - LDA goes T5→T1.
  - OUT and NOP go T4→T1.
  - ADD and SUB still use T6.
- Invariants:
  - At most one of PC_Out, RAM_Out, IR_Out, A_Out, ALU_Out is high in any cycle (single bus driver).
  - No Ld strobe is high during CLR, while halted, or with Run=0.
- CLR mid-instruction abandons the instruction. No partial strobe is emitted in the CLR cycle, and the next cycle is T1.
- Run dropping mid-instruction resumes at the same T-state with identical strobes.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_LDA=4'h0, OP_ADD=4'h1, OP_SUB=4'h2, OP_OUT=4'hE, OP_HLT=4'hF;
  - T-state encodings;
  - a control-word bit-index list, reused by the datapath top.
- One sub-module is natural: tstate_ring. It owns the T1..T6/HALT register, Run/CLR handling and the SKIP_IDLE early-end.
- Microcode decode stays in control_sequencer.

Test Plan:
- Reset: CLR=1 for 2 cycles, Run=1, then release.
  - During CLR: all strobes 0, Halted=0.
  - First cycle after release: TState=1 with PC_Out=MAR_Ld=1.
- LDA: IR_Q=8'h05 (loaded at T3), Run=1.
  - T4: IR_Out+MAR_Ld.
  - T5: RAM_Out+A_Ld.
  - T6: no strobes, then T1.
- SUB: IR_Q=8'h27.
  - T6 shows ALU_Out=A_Ld=ALU_Sub=1.
  - ALU_Sub is 0 in every other T-state.
- HLT: IR_Q=8'hF0.
  - After T4, Halted=1 and TState=0.
  - Holding Run=1 for 10 cycles gives no strobes.
  - CLR then restarts at T1.
- Run gap plus SKIP_IDLE=1: OUT (IR_Q=8'hE0) with Run=0 during T2 for 3 cycles.
  - PC_Inc is absent while Run=0 and asserted exactly once when Run returns.
  - T4 gives A_Out+OUT_Ld, then T1 follows directly.
- Bus-contention assertion: over random IR_Q and Run/CLR pulses for 2000 cycles, at most one bus driver is high every cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, T-state encoding and control-word bit indices
package cpu_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [6:0] {
    ST_T1   = 7'b0000001,
    ST_T2   = 7'b0000010,
    ST_T3   = 7'b0000100,
    ST_T4   = 7'b0001000,
    ST_T5   = 7'b0010000,
    ST_T6   = 7'b0100000,
    ST_HALT = 7'b1000000
  } tstate_e;

  // Bit positions inside the control word; the datapath top indexes the same vector.
  localparam int CW_PC_INC  = 0;
  localparam int CW_PC_OUT  = 1;
  localparam int CW_MAR_LD  = 2;
  localparam int CW_RAM_OUT = 3;
  localparam int CW_IR_LD   = 4;
  localparam int CW_IR_OUT  = 5;
  localparam int CW_A_LD    = 6;
  localparam int CW_A_OUT   = 7;
  localparam int CW_B_LD    = 8;
  localparam int CW_ALU_OUT = 9;
  localparam int CW_ALU_SUB = 10;
  localparam int CW_OUT_LD  = 11;
  localparam int CW_W       = 12;

  function automatic logic [2:0] tstate_num(input tstate_e s);
    case (s)
      ST_T1:   return 3'd1;
      ST_T2:   return 3'd2;
      ST_T3:   return 3'd3;
      ST_T4:   return 3'd4;
      ST_T5:   return 3'd5;
      ST_T6:   return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/tstate_ring.sv
// rtl/tstate_ring.sv - one-hot T1..T6 ring with HALT trap and optional early return to T1
module tstate_ring
  import cpu_pkg::*;
#(
  parameter bit SKIP_IDLE = 1'b0
) (
  input  logic    i_clk,
  input  logic    i_clr,
  input  logic    i_run,
  input  logic    i_halt_req,
  input  logic    i_end_t4,
  input  logic    i_end_t5,
  output tstate_e o_state,
  output logic    o_halted
);

  tstate_e r_state;
  tstate_e w_next;
  logic    r_halted;

  always_comb begin
    w_next = r_state;
    if (i_run) begin
      case (r_state)
        ST_T1:   w_next = ST_T2;
        ST_T2:   w_next = ST_T3;
        ST_T3:   w_next = ST_T4;
        ST_T4: begin
          if (i_halt_req)                w_next = ST_HALT;
          else if (SKIP_IDLE && i_end_t4) w_next = ST_T1;
          else                            w_next = ST_T5;
        end
        ST_T5:   w_next = (SKIP_IDLE && i_end_t5) ? ST_T1 : ST_T6;
        ST_T6:   w_next = ST_T1;
        ST_HALT: w_next = ST_HALT;
        default: w_next = ST_T1;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state  <= ST_T1;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == ST_HALT);
    end
  end

  assign o_state  = r_state;
  assign o_halted = r_halted;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T-state sequencer and microcode decode driving the datapath strobes
module control_sequencer
  import cpu_pkg::*;
#(
  parameter bit SKIP_IDLE = 1'b0,
  parameter int OPW       = 4
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_run,
  input  logic [7:0] i_ir_q,
  output logic       o_pc_inc,
  output logic       o_pc_out,
  output logic       o_mar_ld,
  output logic       o_ram_out,
  output logic       o_ir_ld,
  output logic       o_ir_out,
  output logic       o_a_ld,
  output logic       o_a_out,
  output logic       o_b_ld,
  output logic       o_alu_out,
  output logic       o_alu_sub,
  output logic       o_out_ld,
  output logic       o_halted,
  output logic [2:0] o_tstate
);

  tstate_e           w_state;
  logic [OPW-1:0]    w_opcode;
  logic              w_unused_operand;
  logic              w_is_lda, w_is_add, w_is_sub, w_is_out, w_is_hlt, w_is_nop;
  logic              w_gate;
  logic [CW_W-1:0]   w_cw;

  assign w_opcode         = i_ir_q[7:8-OPW];
  assign w_unused_operand = ^i_ir_q[7-OPW:0];

  assign w_is_lda = (w_opcode == OPW'(OP_LDA));
  assign w_is_add = (w_opcode == OPW'(OP_ADD));
  assign w_is_sub = (w_opcode == OPW'(OP_SUB));
  assign w_is_out = (w_opcode == OPW'(OP_OUT));
  assign w_is_hlt = (w_opcode == OPW'(OP_HLT));
  assign w_is_nop = !(w_is_lda || w_is_add || w_is_sub || w_is_out || w_is_hlt);

  tstate_ring #(.SKIP_IDLE(SKIP_IDLE)) u_ring (
    .i_clk      (i_clk),
    .i_clr      (i_clr),
    .i_run      (i_run),
    .i_halt_req (w_is_hlt),
    .i_end_t4   (w_is_out || w_is_nop),
    .i_end_t5   (w_is_lda),
    .o_state    (w_state),
    .o_halted   (o_halted)
  );

  // Strobes only exist in a running, non-reset cycle; HALT decodes to nothing.
  assign w_gate = i_run && !i_clr;

  always_comb begin
    w_cw = '0;
    if (w_gate) begin
      case (w_state)
        ST_T1: begin
          w_cw[CW_PC_OUT] = 1'b1;
          w_cw[CW_MAR_LD] = 1'b1;
        end
        ST_T2: w_cw[CW_PC_INC] = 1'b1;
        ST_T3: begin
          w_cw[CW_RAM_OUT] = 1'b1;
          w_cw[CW_IR_LD]   = 1'b1;
        end
        ST_T4: begin
          if (w_is_lda || w_is_add || w_is_sub) begin
            w_cw[CW_IR_OUT] = 1'b1;
            w_cw[CW_MAR_LD] = 1'b1;
          end else if (w_is_out) begin
            w_cw[CW_A_OUT]  = 1'b1;
            w_cw[CW_OUT_LD] = 1'b1;
          end
        end
        ST_T5: begin
          if (w_is_lda) begin
            w_cw[CW_RAM_OUT] = 1'b1;
            w_cw[CW_A_LD]    = 1'b1;
          end else if (w_is_add || w_is_sub) begin
            w_cw[CW_RAM_OUT] = 1'b1;
            w_cw[CW_B_LD]    = 1'b1;
          end
        end
        ST_T6: begin
          if (w_is_add || w_is_sub) begin
            w_cw[CW_ALU_OUT] = 1'b1;
            w_cw[CW_A_LD]    = 1'b1;
            w_cw[CW_ALU_SUB] = w_is_sub;
          end
        end
        default: w_cw = '0;
      endcase
    end
  end

  assign o_pc_inc  = w_cw[CW_PC_INC];
  assign o_pc_out  = w_cw[CW_PC_OUT];
  assign o_mar_ld  = w_cw[CW_MAR_LD];
  assign o_ram_out = w_cw[CW_RAM_OUT];
  assign o_ir_ld   = w_cw[CW_IR_LD];
  assign o_ir_out  = w_cw[CW_IR_OUT];
  assign o_a_ld    = w_cw[CW_A_LD];
  assign o_a_out   = w_cw[CW_A_OUT];
  assign o_b_ld    = w_cw[CW_B_LD];
  assign o_alu_out = w_cw[CW_ALU_OUT];
  assign o_alu_sub = w_cw[CW_ALU_SUB];
  assign o_out_ld  = w_cw[CW_OUT_LD];
  assign o_tstate  = tstate_num(w_state);

endmodule
